// File: rtl/du_regfile_dumper.sv
// Debug-unit register-file dumper: freezes the pipeline, reads every register through the
// ID-stage debug port and streams each word as four bytes over a valid/ready byte link.
module du_regfile_dumper #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_du_reg_addr,
    input  logic [DATA_W-1:0] i_du_reg_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_pipe_hold,
    output logic              o_busy,
    output logic              o_done
);

    // Byte link: a byte moves at a rising edge where o_tx_valid & i_tx_ready; while valid is
    // high and ready is low, o_tx_data is held and valid is never withdrawn.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_SEND = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_shift;
    logic [1:0]          r_byte_cnt;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_pipe_hold;
    logic                r_busy;
    logic                r_done;

    logic                w_xfer;
    logic [DATA_W-1:0]   w_shifted;

    // The outgoing byte always sits at the "send end" of the shift register.
    function automatic logic [7:0] send_byte(input logic [DATA_W-1:0] word);
        if (BIG_ENDIAN != 0) begin
            return word[DATA_W-1 -: 8];
        end
        return word[7:0];
    endfunction

    assign w_xfer    = r_tx_valid & i_tx_ready;
    assign w_shifted = (BIG_ENDIAN != 0) ? (r_shift << 8) : (r_shift >> 8);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_pipe_hold <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr      <= '0;
                        r_busy      <= 1'b1;
                        r_pipe_hold <= 1'b1;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_shift    <= i_du_reg_data;
                    r_tx_data  <= send_byte(i_du_reg_data);
                    r_byte_cnt <= '0;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_byte_cnt == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= S_NEXT;
                        end else begin
                            r_shift    <= w_shifted;
                            r_tx_data  <= send_byte(w_shifted);
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                S_NEXT: begin
                    if (r_addr == LAST_ADDR) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_pipe_hold <= 1'b0;
                    r_addr      <= '0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_du_reg_addr = r_addr;
    assign o_tx_data     = r_tx_data;
    assign o_tx_valid    = r_tx_valid;
    assign o_pipe_hold   = r_pipe_hold;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_du_regfile_dumper.sv
// Bench for du_regfile_dumper: a big-endian and a little-endian instance share one register
// file model and one byte link; captured streams are checked against expected byte queues.
module tb_du_regfile_dumper;
    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, ready;
    logic [31:0] rf [N];

    logic [4:0]  addr_be, addr_le;
    logic [31:0] data_be, data_le;
    logic [7:0]  txd_be, txd_le;
    logic        v_be, v_le, hold_be, hold_le, busy_be, busy_le, done_be, done_le;

    assign data_be = rf[addr_be];
    assign data_le = rf[addr_le];

    du_regfile_dumper #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32), .BIG_ENDIAN(1)) u_be (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .o_du_reg_addr(addr_be),
        .i_du_reg_data(data_be), .o_tx_data(txd_be), .o_tx_valid(v_be), .i_tx_ready(ready),
        .o_pipe_hold(hold_be), .o_busy(busy_be), .o_done(done_be));

    du_regfile_dumper #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32), .BIG_ENDIAN(0)) u_le (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .o_du_reg_addr(addr_le),
        .i_du_reg_data(data_le), .o_tx_data(txd_le), .o_tx_valid(v_le), .i_tx_ready(ready),
        .o_pipe_hold(hold_le), .o_busy(busy_le), .o_done(done_le));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int s_cyc = 0;
    int done_cyc = 0;
    int done_cnt_be = 0;
    int done_cnt_le = 0;
    int rdy_mode = 0;

    logic [7:0] got_be[$], got_le[$];
    logic [7:0] exp_be_q[$], exp_le_q[$];

    logic       pv_be = 1'b0, pv_le = 1'b0, pr = 1'b0;
    logic [7:0] pd_be = 8'h0, pd_le = 8'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            2:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
        endcase
    end

    // Link monitor: capture transfers, check stall stability, hold while busy, count o_done.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_be = 1'b0;
            pv_le = 1'b0;
        end else begin
            if (pv_be && !pr) begin
                check("be_stall_valid", 32'(v_be), 32'd1);
                check("be_stall_data", 32'(txd_be), 32'(pd_be));
            end
            if (pv_le && !pr) begin
                check("le_stall_valid", 32'(v_le), 32'd1);
                check("le_stall_data", 32'(txd_le), 32'(pd_le));
            end
            if (v_be && ready) got_be.push_back(txd_be);
            if (v_le && ready) got_le.push_back(txd_le);
            if (busy_be) check("be_hold_busy", 32'(hold_be), 32'd1);
            if (busy_le) check("le_hold_busy", 32'(hold_le), 32'd1);
            if (done_be) begin
                done_cnt_be++;
                done_cyc = cyc;
            end
            if (done_le) done_cnt_le++;
            pv_be = v_be;
            pv_le = v_le;
            pd_be = txd_be;
            pd_le = txd_le;
            pr    = ready;
        end
    end

    task automatic build_exp();
        exp_be_q.delete();
        exp_le_q.delete();
        for (int k = 0; k < N; k++) begin
            for (int b = 0; b < 4; b++) begin
                exp_be_q.push_back(8'(rf[k] >> (8 * (3 - b))));
                exp_le_q.push_back(8'(rf[k] >> (8 * b)));
            end
        end
    endtask

    task automatic preload_pattern();
        rf[0] = 32'h0;
        for (int k = 1; k < N; k++) rf[k] = 32'hA500_0000 | 32'(k);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        s_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    int d0_be, d0_le;

    task automatic start_dump();
        build_exp();
        got_be.delete();
        got_le.delete();
        d0_be = done_cnt_be;
        d0_le = done_cnt_le;
        pulse_start();
    endtask

    task automatic wait_dump(input string tag, input bit chk_time);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt_be != d0_be) break;
            check({tag, "_busy"}, 32'(busy_be), 32'd1);
        end
        check({tag, "_timeout"}, 32'(i < 4000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_be"}, 32'(done_cnt_be - d0_be), 32'd1);
        check({tag, "_done_le"}, 32'(done_cnt_le - d0_le), 32'd1);
        if (chk_time) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(s_cyc + 1 + 6 * N));
        check({tag, "_idle_busy"}, 32'({busy_be, busy_le}), 32'd0);
        check({tag, "_idle_hold"}, 32'({hold_be, hold_le}), 32'd0);
        check({tag, "_idle_valid"}, 32'({v_be, v_le}), 32'd0);
        check({tag, "_idle_addr"}, 32'({addr_be, addr_le}), 32'd0);
        check({tag, "_n_be"}, 32'(got_be.size()), 32'(4 * N));
        check({tag, "_n_le"}, 32'(got_le.size()), 32'(4 * N));
        for (int j = 0; j < 4 * N && j < got_be.size() && j < got_le.size(); j++) begin
            check({tag, "_byte_be"}, 32'(got_be[j]), 32'(exp_be_q[j]));
            check({tag, "_byte_le"}, 32'(got_le[j]), 32'(exp_le_q[j]));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        ready    = 1'b0;
        rdy_mode = 0;
        for (int k = 0; k < N; k++) rf[k] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 32'({addr_be, addr_le}), 32'd0);
        check("rst_data", 32'({txd_be, txd_le}), 32'd0);
        check("rst_valid", 32'({v_be, v_le}), 32'd0);
        check("rst_hold", 32'({hold_be, hold_le}), 32'd0);
        check("rst_busy", 32'({busy_be, busy_le}), 32'd0);
        check("rst_done", 32'({done_be, done_le}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Pattern dump at full rate, with cycle-exact o_done.
        preload_pattern();
        start_dump();
        check("t1_hold_after_start", 32'(hold_be), 32'd1);
        wait_dump("t1", 1'b1);
        check("t1_b0", 32'(got_be[0]), 32'h00);
        check("t1_b4", 32'(got_be[4]), 32'hA5);
        check("t1_b7", 32'(got_be[7]), 32'h01);
        check("t1_last", 32'(got_be[4 * N - 1]), 32'h1F);

        // Same data with ready toggling.
        rdy_mode = 1;
        start_dump();
        wait_dump("t2", 1'b0);
        rdy_mode = 0;

        // Little-endian ordering of a known word.
        rf[1] = 32'h1122_3344;
        start_dump();
        wait_dump("t3", 1'b1);
        check("t3_le_b4", 32'(got_le[4]), 32'h44);
        check("t3_le_b5", 32'(got_le[5]), 32'h33);
        check("t3_le_b6", 32'(got_le[6]), 32'h22);
        check("t3_le_b7", 32'(got_le[7]), 32'h11);

        // i_start pulses mid-dump are ignored.
        preload_pattern();
        start_dump();
        repeat (8) @(posedge clk);
        pulse_start();
        repeat (38) @(posedge clk);
        pulse_start();
        wait_dump("t4", 1'b0);

        // Reset mid-dump, then a clean restart.
        start_dump();
        for (int i = 0; i < 2000 && got_be.size() < 50; i++) @(posedge clk);
        check("t5_reach50", 32'(got_be.size() >= 50), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'({v_be, v_le}), 32'd0);
        check("t5_async_busy", 32'({busy_be, busy_le}), 32'd0);
        check("t5_async_hold", 32'({hold_be, hold_le}), 32'd0);
        d0_be = done_cnt_be;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        check("t5_no_done", 32'(done_cnt_be - d0_be), 32'd0);
        start_dump();
        wait_dump("t5", 1'b1);

        // Long stall mid-word.
        start_dump();
        for (int i = 0; i < 2000 && got_be.size() < 10; i++) @(posedge clk);
        rdy_mode = 3;
        repeat (20) @(posedge clk);
        rdy_mode = 0;
        wait_dump("t6", 1'b0);

        // Random register contents with random ready.
        for (int r = 0; r < 3; r++) begin
            rf[0] = 32'h0;
            for (int k = 1; k < N; k++) rf[k] = $urandom();
            rdy_mode = (r == 0) ? 0 : 2;
            start_dump();
            wait_dump("rnd", r == 0);
        end
        rdy_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
